// File: rtl/memory_game_pkg.sv
// memory_game_pkg: shared state encoding, score codes and LED/switch helpers for the autoplayer
package memory_game_pkg;
  typedef enum logic [2:0] {S_IDLE, S_START, S_WATCH, S_PLAY, S_DONE} state_t;
  localparam logic [3:0] SCORE_WIN = 4'hA;
  localparam logic [3:0] SCORE_LOSE = 4'hE;
  localparam logic [3:0] START_SWITCHES = 4'b0011;
  function automatic logic is_one_hot(input logic [3:0] v);
    return (v != 4'b0) && ((v & (v - 4'd1)) == 4'b0);
  endfunction
  function automatic logic [1:0] one_hot_index(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int k = 0; k < 4; k++) if (v[k]) r = 2'(k);
    return r;
  endfunction
  function automatic logic [3:0] index_to_one_hot(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction
endpackage

// File: rtl/memory_pattern_buffer.sv
// memory_pattern_buffer: append-only store of captured LED indices with indexed replay
module memory_pattern_buffer #(
  parameter int MAX_DEPTH = 8,
  parameter int IW = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1,
  parameter int CW = $clog2(MAX_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          wr_en,
  input  logic [1:0]    wr_data,
  input  logic [IW-1:0] rd_idx,
  output logic [1:0]    rd_data,
  output logic [CW-1:0] count,
  output logic          full
);
  logic [1:0] mem [MAX_DEPTH];
  assign full = count == CW'(MAX_DEPTH);
  assign rd_data = mem[rd_idx];
  // fill level: clear wins over append, appends beyond capacity are refused
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (clear) count <= '0;
    else if (wr_en && !full) count <= count + 1'b1;
  // storage needs no reset, only entries below count are ever read
  always_ff @(posedge clk)
    if (wr_en && !full && !clear) mem[count[IW-1:0]] <= wr_data;
endmodule

// File: rtl/memory_game_autoplayer.sv
// memory_game_autoplayer: records the game's LED patterns and replays them on the switch inputs
module memory_game_autoplayer
  import memory_game_pkg::*;
#(
  parameter int CLKS_PER_SEC = 25000000,
  parameter int MAX_DEPTH = 8,
  parameter int PRESS_CLKS = CLKS_PER_SEC / 10,
  parameter int GAP_CLKS = CLKS_PER_SEC / 10,
  parameter int QUIET_CLKS = CLKS_PER_SEC
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Enable,
  input  logic [3:0] i_LED,
  input  logic [3:0] i_Score,
  output logic [3:0] o_Switch,
  output logic       o_Busy,
  output logic       o_Done,
  output logic       o_Win,
  output logic       o_Overflow
);
  localparam int PG = (PRESS_CLKS > GAP_CLKS) ? PRESS_CLKS : GAP_CLKS;
  localparam int TMAX = (PG > QUIET_CLKS) ? PG : QUIET_CLKS;
  localparam int TW = $clog2(TMAX) + 1;
  localparam int IW = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
  localparam int CW = $clog2(MAX_DEPTH + 1);
  localparam logic [TW-1:0] PRESS_LAST = TW'(PRESS_CLKS - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CLKS - 1);
  localparam logic [TW-1:0] QUIET_LAST = TW'(QUIET_CLKS - 1);
  state_t state, state_nx;
  logic [TW-1:0] tmr, tmr_nx;
  logic [IW-1:0] idx, idx_nx;
  logic gap, gap_nx, win, win_nx, ovf, ovf_nx;
  logic [3:0] led_q, led_prev;
  logic buf_wr, buf_clr, buf_full;
  logic [1:0] buf_rd;
  logic [CW-1:0] buf_count;
  logic capture, busy, scoring, score_end, last_entry;
  memory_pattern_buffer #(.MAX_DEPTH(MAX_DEPTH), .IW(IW), .CW(CW)) u_buf (
    .clk(i_Clk),
    .rst_n(i_Rst_L),
    .clear(buf_clr),
    .wr_en(buf_wr),
    .wr_data(one_hot_index(led_q)),
    .rd_idx(idx),
    .rd_data(buf_rd),
    .count(buf_count),
    .full(buf_full)
  );
  assign capture = is_one_hot(led_q) && led_prev == 4'b0;
  assign busy = state == S_START || state == S_WATCH || state == S_PLAY;
  assign scoring = state == S_WATCH || state == S_PLAY;
  assign score_end = i_Score == SCORE_WIN || i_Score == SCORE_LOSE;
  assign last_entry = idx == IW'(buf_count - 1'b1);
  assign o_Switch = (state == S_START) ? START_SWITCHES :
                    (state == S_PLAY && !gap) ? index_to_one_hot(buf_rd) : 4'b0;
  assign o_Busy = busy;
  assign o_Done = state == S_DONE;
  assign o_Win = win;
  assign o_Overflow = ovf;
  // state, timers and LED history; the LED pair gives a one-cycle edge compare
  always_ff @(posedge i_Clk or negedge i_Rst_L)
    if (!i_Rst_L) begin
      state <= S_IDLE;
      tmr <= '0;
      idx <= '0;
      gap <= 1'b0;
      win <= 1'b0;
      ovf <= 1'b0;
      led_q <= 4'b0;
      led_prev <= 4'b0;
    end else begin
      state <= state_nx;
      tmr <= tmr_nx;
      idx <= idx_nx;
      gap <= gap_nx;
      win <= win_nx;
      ovf <= ovf_nx;
      led_q <= i_LED;
      led_prev <= led_q;
    end
  // next state: per-state phases first, then abort, then game-over which overrides everything
  always_comb begin
    state_nx = state;
    tmr_nx = tmr;
    idx_nx = idx;
    gap_nx = gap;
    win_nx = win;
    ovf_nx = ovf;
    buf_wr = 1'b0;
    buf_clr = 1'b0;
    case (state)
      S_IDLE: if (i_Enable) begin
        state_nx = S_START;
        tmr_nx = '0;
        buf_clr = 1'b1;
      end
      S_START: begin
        tmr_nx = (tmr == PRESS_LAST) ? '0 : tmr + 1'b1;
        if (tmr == PRESS_LAST) state_nx = S_WATCH;
      end
      S_WATCH: begin
        tmr_nx = (led_q != 4'b0) ? '0 : (tmr == QUIET_LAST) ? tmr : tmr + 1'b1;
        if (led_q == 4'b0 && tmr == QUIET_LAST && buf_count != '0) begin
          state_nx = S_PLAY;
          tmr_nx = '0;
          idx_nx = '0;
          gap_nx = 1'b0;
        end
        if (capture) begin
          buf_wr = !buf_full;
          ovf_nx = ovf | buf_full;
        end
      end
      S_PLAY: begin
        tmr_nx = tmr + 1'b1;
        if (!gap && tmr == PRESS_LAST) begin
          gap_nx = 1'b1;
          tmr_nx = '0;
        end
        if (gap && tmr == GAP_LAST) begin
          gap_nx = 1'b0;
          tmr_nx = '0;
          idx_nx = idx + 1'b1;
          state_nx = last_entry ? S_WATCH : S_PLAY;
          buf_clr = last_entry;
        end
      end
      S_DONE: if (!i_Enable) begin
        state_nx = S_IDLE;
        win_nx = 1'b0;
      end
      default: state_nx = S_IDLE;
    endcase
    if (busy && !i_Enable) begin
      state_nx = S_IDLE;
      tmr_nx = '0;
      gap_nx = 1'b0;
      buf_wr = 1'b0;
      buf_clr = 1'b1;
      ovf_nx = ovf;
    end
    if (scoring && score_end) begin
      state_nx = S_DONE;
      tmr_nx = '0;
      gap_nx = 1'b0;
      win_nx = i_Score == SCORE_WIN;
      buf_wr = 1'b0;
      ovf_nx = ovf;
    end
  end
endmodule

// File: doc/memory_game_autoplayer.md
Name: memory_game_autoplayer

Overview:
- Automated opponent for the memory game, used for board bring-up and soak testing without a human.
- Watches the four game LEDs, records each pattern the game displays, then replays it by driving the four switch inputs with human-like press and release timing.
- Sits in place of the debounced switch inputs and monitors the game's 4-bit score.
- Reports a win (score 0xA) or a loss (score 0xE).

Parameters:
- CLKS_PER_SEC, 25000000, clock rate; documentation only, no logic depends on it.
- MAX_DEPTH, 8, pattern buffer entries; must be at least the game limit + 1.
- PRESS_CLKS, 2500000, cycles each switch is held asserted (100 ms).
- GAP_CLKS, 2500000, cycles all switches are released between presses.
- QUIET_CLKS, 25000000, cycles of all-LEDs-off that end pattern capture (1 s).

Ports:
- i_Clk  in  1  system clock.
- i_Rst_L  in  1  asynchronous active-low reset.
- i_Enable  in  1  level; high runs the player, low aborts to IDLE.
- i_LED  in  4  game LED outputs, bit0 = LED_1.
- i_Score  in  4  game score.
- o_Switch  out  4  switch drive into the game, bit0 = Switch_1.
- o_Busy  out  1  high in any state except IDLE and DONE.
- o_Done  out  1  high in DONE.
- o_Win  out  1  valid while o_Done; 1 = score 0xA seen.
- o_Overflow  out  1  sticky; a capture was dropped because the buffer was full.

Behaviour:
- Reset (async assert, sync release): state IDLE; o_Switch = 0; o_Busy, o_Done, o_Win, o_Overflow = 0; buffer count = 0; timers = 0.
- i_LED is registered once. Edge detection compares the registered value with its previous value.
- States:
  - IDLE: wait for i_Enable = 1, then go to START.
  - START: drive o_Switch = 4'b0011 for PRESS_CLKS cycles, then 0. Go to WATCH.
  - WATCH: a capture event is a cycle where the registered LEDs are exactly one-hot and the previous registered value was 0. On a capture event, append the LED index (2 bits) to the buffer. Non-one-hot patterns are ignored.
    - The quiet timer counts consecutive cycles with registered LEDs = 0 and resets on any nonzero value.
    - When the quiet timer reaches QUIET_CLKS with count > 0, go to PLAY.
    - With count = 0, stay in WATCH indefinitely.
  - PLAY: for each entry in order, drive o_Switch to the one-hot value of that index for PRESS_CLKS cycles, then 0 for GAP_CLKS cycles. After the last entry, clear count to 0 and go to WATCH.
  - DONE: o_Switch = 0, o_Done = 1. Hold until i_Enable = 0, then go to IDLE; o_Done and o_Win clear on leaving DONE.
- Score check, evaluated in WATCH and PLAY:
  - i_Score = 0xA: go to DONE with o_Win = 1.
  - i_Score = 0xE: go to DONE with o_Win = 0.
  - This takes priority over all other transitions in the same cycle.
  - o_Switch is forced to 0 on the entry cycle.
- i_Enable = 0 in any busy state: next cycle state is IDLE, o_Switch = 0, count cleared. o_Overflow is kept; it clears only on reset.
- Buffer full (count = MAX_DEPTH) on a capture event: drop the entry and set o_Overflow.
- Timers:
  - Width is clog2 of the largest of PRESS_CLKS, GAP_CLKS and QUIET_CLKS, plus 1.
  - Each timer counts 0 up to the limit − 1 (exactly N cycles), with no wrap.
- o_Switch changes only on state or phase boundaries and never has more than one bit set, except during START.
- Output latency: a switch drive begins on the first PLAY cycle. LED capture latency is 2 cycles (register + edge compare).

Decomposition:
- Package memory_game_pkg:
  - state encoding (IDLE, START, WATCH, PLAY, DONE);
  - SCORE_WIN = 4'hA, SCORE_LOSE = 4'hE;
  - START_SWITCHES = 4'b0011;
  - function for one-hot check and index-to-one-hot conversion.
- Sub-module memory_pattern_buffer: MAX_DEPTH × 2-bit store with write-append, indexed read, count and clear, and a full flag.
- The FSM and timers stay in the top of this block.

Test Plan (PRESS_CLKS = 4, GAP_CLKS = 3, QUIET_CLKS = 10, MAX_DEPTH = 4):
- Reset mid-PLAY → all outputs 0 immediately, state IDLE.
- i_Enable rises → o_Switch = 0011 for exactly 4 cycles, then 0; o_Busy = 1.
- LED pattern 0100, off 5, 0001, off 10 → PLAY drives 0100×4, 0×3, 0001×4, 0×3, then WATCH with count 0.
- LEDs 0110 pulse, then 0010, off 10 → only index 1 captured; replay is 0010×4.
- 5 one-hot pulses → 4 replayed, o_Overflow = 1 and still 1 after i_Enable toggles.
- i_Score = 0xE during PLAY → o_Switch = 0 on the same cycle as DONE entry; o_Done = 1, o_Win = 0.
- i_Score = 0xA → o_Win = 1; drop i_Enable → o_Done = 0, state IDLE.
